cond_logic: RTL and testbench
=============================

# cond_logic

Conditional-execution stage directly downstream of the main/ALU decoder. It evaluates the instruction's 4-bit condition field against the stored NZCV flags and holds those flags in two independently-enabled registers (NZ, CV). It gates the decoder's raw PCS/RegW/MemW/FlagW strobes into architectural write enables for the PC mux, register file, data memory and the flag registers themselves. It sits between the decoder and the datapath write ports.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- Cond  in  4  instruction condition field, Instr[31:28]
- ALUFlags  in  4  {N,Z,C,V} from the ALU for the current instruction
- FlagW  in  2  from decoder; [1] requests NZ update, [0] requests CV update
- PCS  in  1  from decoder; instruction writes PC (branch or Rd==15)
- RegW  in  1  from decoder; instruction writes register file
- MemW  in  1  from decoder; instruction writes data memory
- NextPC  in  1  only with COND_MULTICYCLE_EN; FSM fetch-stage PC increment
- PCSrc  out  1  PCS & CondEx (single-cycle build)
- PCWrite  out  1  only with COND_MULTICYCLE_EN; (PCS & CondExReg) | NextPC
- RegWrite  out  1  gated register-file write enable
- MemWrite  out  1  gated memory write enable
- Flags  out  4  current stored {N,Z,C,V}; observable for debug and bench

## Operation
- CondEx (combinational), evaluated from stored Flags, never from ALUFlags:
  - 0000 EQ: Z. 0001 NE: !Z
  - 0010 CS: C. 0011 CC: !C
  - 0100 MI: N. 0101 PL: !N
  - 0110 VS: V. 0111 VC: !V
  - 1000 HI: C & !Z. 1001 LS: !C | Z
  - 1010 GE: N==V. 1011 LT: N!=V
  - 1100 GT: !Z & (N==V). 1101 LE: Z | (N!=V)
  - 1110 AL: 1. 1111: 1 (treated as unconditional)
- Flag registers:
  - FlagWrite[1] = FlagW[1] & CondEx; when set, Flags[3:2] <= ALUFlags[3:2].
  - FlagWrite[0] = FlagW[0] & CondEx; when set, Flags[1:0] <= ALUFlags[1:0].
  - Each half holds its value otherwise. Halves update independently: logical ops with S set touch only NZ, so C and V survive.
- Gated outputs (single-cycle build):
  - PCSrc = PCS & CondEx
  - RegWrite = RegW & CondEx
  - MemWrite = MemW & CondEx
- A failed condition suppresses every side effect, including flag writes.
- X on FlagW/PCS/RegW/MemW (unimplemented op) while CondEx=0 resolves to 0 on the gated outputs.

## Timing
- Reset: Flags=4'b0000; CondExReg=0 (multicycle build). Outputs then follow from the combinational equations on the reset flags (Cond=EQ -> CondEx=0).
- Reset held with FlagW=2'b11: Flags stay 0; reset has priority over flag writes.
- Flag update latency: 1 cycle. An instruction's condition sees flags from prior instructions only. A flag-setting instruction's own CondEx uses pre-update flags.
- Back-to-back: a compare in cycle n followed by a conditional instruction in cycle n+1 sees the updated flags.
- Gated enables are combinational from Cond, Flags and the strobes, with zero latency (single-cycle build).

## Configuration
- COND_MULTICYCLE_EN undefined (default): single-cycle build. No NextPC/PCWrite ports; all gating uses combinational CondEx.
- COND_MULTICYCLE_EN defined:
  - CondExReg <= CondEx every cycle; decode state evaluates the condition, later states write.
  - RegWrite = RegW & CondExReg; MemWrite = MemW & CondExReg.
  - PCWrite = (PCS & CondExReg) | NextPC; PCSrc port removed.
  - Flag writes still use combinational CondEx.
  - Reset mid-instruction clears CondExReg, so no stale write enable survives reset.

## Test plan
- Reset with FlagW=11, ALUFlags=1111 for 2 cycles -> Flags=0000. Release with Cond=0000, RegW=1 -> RegWrite=0.
- Cond=1110, FlagW=11, ALUFlags=0110 -> next cycle Flags=0110. Then Cond=0000 (EQ), RegW=1 -> RegWrite=1; Cond=0001, MemW=1 -> MemWrite=0.
- Flags=0011, Cond=1110, FlagW=10, ALUFlags=1100 -> Flags=1111 (CV preserved). Then FlagW=01, ALUFlags=0000 -> Flags=1100.
- Flags=1000 (N!=V): Cond=1011 (LT) -> CondEx=1, so PCS=1 gives PCSrc=1; Cond=1100 (GT) with FlagW=11 -> PCSrc=0 and Flags unchanged next cycle.
- Sweep all 16 Cond values x all 16 Flags values with RegW=1 -> RegWrite matches the condition equations above (256 checks).
- COND_MULTICYCLE_EN: Flags=0100, Cond=0000 in cycle n, Cond=0001 in cycle n+1 with RegW=1 -> RegWrite=1 in n+1 (uses CondExReg from n). NextPC=1 with PCS=0 -> PCWrite=1.

Source files
------------

// File: rtl/cond_logic.sv
// cond_logic: conditional-execution stage sitting between the main/ALU
// decoder and the datapath write ports.
//
// Evaluates the 4-bit condition field against the stored NZCV flags. The
// flags live in two independently enabled halves (NZ and CV). The decoder's
// raw strobes are gated into architectural write enables.
//
// Optional feature macro: COND_MULTICYCLE_EN
//   undefined (default) : single-cycle build. PCSrc/RegWrite/MemWrite are
//                         gated by the combinational condition result.
//   defined             : multicycle build. The condition result is
//                         registered every cycle (r_cond_ex). The write
//                         enables use that registered copy, and a
//                         PCWrite = (PCS & r_cond_ex) | NextPC output
//                         replaces PCSrc.
module cond_logic (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
`ifdef COND_MULTICYCLE_EN
  input  logic       NextPC,
  output logic       PCWrite,
`else
  output logic       PCSrc,
`endif
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [3:0] Flags
);

  // Condition field encodings, Instr[31:28].
  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  // Stored flags. NZ is stored as {N,Z} and CV as {C,V}.
  logic [1:0] r_flags_nz;
  logic [1:0] r_flags_cv;

  // Individual flag bits taken from the stored state, never from ALUFlags.
  logic w_n;
  logic w_z;
  logic w_c;
  logic w_v;
  logic w_n_eq_v;

  logic  w_cond_ex;
  logic  [1:0] w_flag_write;
  cond_e w_cond;

  assign w_cond   = cond_e'(Cond);
  assign w_n      = r_flags_nz[1];
  assign w_z      = r_flags_nz[0];
  assign w_c      = r_flags_cv[1];
  assign w_v      = r_flags_cv[0];
  assign w_n_eq_v = (w_n == w_v);

  // Evaluate the condition field against the stored flags.
  always_comb begin
    w_cond_ex = 1'b1;
    unique case (w_cond)
      COND_EQ: w_cond_ex = w_z;
      COND_NE: w_cond_ex = ~w_z;
      COND_CS: w_cond_ex = w_c;
      COND_CC: w_cond_ex = ~w_c;
      COND_MI: w_cond_ex = w_n;
      COND_PL: w_cond_ex = ~w_n;
      COND_VS: w_cond_ex = w_v;
      COND_VC: w_cond_ex = ~w_v;
      COND_HI: w_cond_ex = w_c & ~w_z;
      COND_LS: w_cond_ex = ~w_c | w_z;
      COND_GE: w_cond_ex = w_n_eq_v;
      COND_LT: w_cond_ex = ~w_n_eq_v;
      COND_GT: w_cond_ex = ~w_z & w_n_eq_v;
      COND_LE: w_cond_ex = w_z | ~w_n_eq_v;
      COND_AL: w_cond_ex = 1'b1;
      COND_NV: w_cond_ex = 1'b1;  // reserved encoding runs unconditionally
      default: w_cond_ex = 1'b1;
    endcase
  end

  // Flag writes always use the combinational result, so a flag-setting
  // instruction is judged on the flags left by earlier instructions. A failed
  // condition drops the write. The AND with a 0 also forces X strobes to 0.
  assign w_flag_write[1] = FlagW[1] & w_cond_ex;
  assign w_flag_write[0] = FlagW[0] & w_cond_ex;

  // NZ half: updated alone by logical ops with S set, so C and V survive.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags_nz <= 2'b00;
    end else if (w_flag_write[1]) begin
      r_flags_nz <= ALUFlags[3:2];
    end
  end

  // CV half: independent enable from the NZ half.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_flags_cv <= 2'b00;
    end else if (w_flag_write[0]) begin
      r_flags_cv <= ALUFlags[1:0];
    end
  end

  assign Flags = {r_flags_nz, r_flags_cv};

`ifdef COND_MULTICYCLE_EN
  // The decode state evaluates the condition, and later states write using
  // this held copy. Reset clears it so no stale enable outlives a reset.
  logic r_cond_ex;

  // Capture the condition result every cycle for use by the write states.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cond_ex <= 1'b0;
    end else begin
      r_cond_ex <= w_cond_ex;
    end
  end

  assign PCWrite  = (PCS & r_cond_ex) | NextPC;
  assign RegWrite = RegW & r_cond_ex;
  assign MemWrite = MemW & r_cond_ex;
`else
  // Single-cycle build: zero-latency gating from the combinational result.
  assign PCSrc    = PCS  & w_cond_ex;
  assign RegWrite = RegW & w_cond_ex;
  assign MemWrite = MemW & w_cond_ex;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic. Expected values are pushed to a
// scoreboard queue as stimulus is applied. Each scenario task pops and
// compares them once the DUT output is settled. When built with
// COND_MULTICYCLE_EN, the single-cycle gating scenarios are replaced by a
// registered-condition scenario.
module tb_cond_logic;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
`ifdef COND_MULTICYCLE_EN
  logic       NextPC;
  logic       PCWrite;
`else
  logic       PCSrc;
`endif

  int         total = 0;
  int         bad   = 0;
  logic [3:0] sb_q[$];
  logic [3:0] exp_v;

  always #5 clk = ~clk;

  cond_logic dut (
    .clk      (clk),
    .reset    (reset),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
`ifdef COND_MULTICYCLE_EN
    .NextPC   (NextPC),
    .PCWrite  (PCWrite),
`else
    .PCSrc    (PCSrc),
`endif
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .Flags    (Flags)
  );

  // Reference condition model. It is organised as a base test plus an
  // inversion bit, not as a 16-way table.
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n  = f[3];
    z  = f[2];
    cf = f[1];
    v  = f[0];
    if (c[3:1] == 3'b111) return 1'b1;
    case (c[3:1])
      3'b000:  base = z;
      3'b001:  base = cf;
      3'b010:  base = n;
      3'b011:  base = v;
      3'b100:  base = cf & ~z;
      3'b101:  base = (n == v);
      default: base = ~z & (n == v);
    endcase
    return c[0] ? ~base : base;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    FlagW = 2'b00;
    PCS   = 1'b0;
    RegW  = 1'b0;
    MemW  = 1'b0;
`ifdef COND_MULTICYCLE_EN
    NextPC = 1'b0;
`endif
  endtask

  // Load the stored flags through an unconditional full flag write.
  task automatic set_flags(input logic [3:0] f);
    idle_inputs();
    Cond     = 4'b1110;
    FlagW    = 2'b11;
    ALUFlags = f;
    step();
    FlagW = 2'b00;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset    = 1'b1;
    Cond     = 4'b1110;
    FlagW    = 2'b11;
    ALUFlags = 4'b1111;
    step();
    step();
    sb_q.push_back(4'b0000);
    exp_v = sb_q.pop_front();
    total++;
    if (Flags !== exp_v) begin
      bad++;
      $display("FAIL reset_flags: got=%b want=%b", Flags, exp_v);
    end
    $display("reset held with FlagW=11: Flags=%b", Flags);
    reset = 1'b0;
    FlagW = 2'b00;
    Cond  = 4'b0000;
    RegW  = 1'b1;
    #1;
    sb_q.push_back({3'b000, model_cond(4'b0000, 4'b0000)});
    exp_v = sb_q.pop_front();
    total++;
    if (RegWrite !== exp_v[0]) begin
      bad++;
      $display("FAIL reset_eq_regwrite: got=%b want=%b", RegWrite, exp_v[0]);
    end
    $display("after reset Cond=EQ RegW=1: RegWrite=%b", RegWrite);
    idle_inputs();
  endtask

  task automatic test_flag_update();
    idle_inputs();
    Cond     = 4'b1110;
    FlagW    = 2'b11;
    ALUFlags = 4'b0110;
    sb_q.push_back(4'b0110);
    step();
    FlagW = 2'b00;
    #1;
    exp_v = sb_q.pop_front();
    total++;
    if (Flags !== exp_v) begin
      bad++;
      $display("FAIL flag_update: got=%b want=%b", Flags, exp_v);
    end
    $display("AL FlagW=11 ALUFlags=0110: Flags=%b", Flags);
`ifndef COND_MULTICYCLE_EN
    Cond = 4'b0000;
    RegW = 1'b1;
    #1;
    sb_q.push_back(4'b0001);
    exp_v = sb_q.pop_front();
    total++;
    if (RegWrite !== exp_v[0]) begin
      bad++;
      $display("FAIL eq_regwrite: got=%b want=%b", RegWrite, exp_v[0]);
    end
    $display("EQ with Z=1 RegW=1: RegWrite=%b", RegWrite);
    Cond = 4'b0001;
    RegW = 1'b0;
    MemW = 1'b1;
    #1;
    sb_q.push_back(4'b0000);
    exp_v = sb_q.pop_front();
    total++;
    if (MemWrite !== exp_v[0]) begin
      bad++;
      $display("FAIL ne_memwrite: got=%b want=%b", MemWrite, exp_v[0]);
    end
    $display("NE with Z=1 MemW=1: MemWrite=%b", MemWrite);
`endif
    idle_inputs();
  endtask

  task automatic test_split_halves();
    set_flags(4'b0011);
    Cond     = 4'b1110;
    FlagW    = 2'b10;
    ALUFlags = 4'b1100;
    sb_q.push_back(4'b1111);
    step();
    exp_v = sb_q.pop_front();
    total++;
    if (Flags !== exp_v) begin
      bad++;
      $display("FAIL nz_only: got=%b want=%b", Flags, exp_v);
    end
    $display("FlagW=10 ALUFlags=1100: Flags=%b", Flags);
    FlagW    = 2'b01;
    ALUFlags = 4'b0000;
    sb_q.push_back(4'b1100);
    step();
    exp_v = sb_q.pop_front();
    total++;
    if (Flags !== exp_v) begin
      bad++;
      $display("FAIL cv_only: got=%b want=%b", Flags, exp_v);
    end
    $display("FlagW=01 ALUFlags=0000: Flags=%b", Flags);
    idle_inputs();
  endtask

`ifndef COND_MULTICYCLE_EN
  task automatic test_cond_fail();
    set_flags(4'b1000);
    Cond = 4'b1011;
    PCS  = 1'b1;
    #1;
    sb_q.push_back({3'b000, model_cond(4'b1011, 4'b1000)});
    exp_v = sb_q.pop_front();
    total++;
    if (PCSrc !== exp_v[0]) begin
      bad++;
      $display("FAIL lt_pcsrc: got=%b want=%b", PCSrc, exp_v[0]);
    end
    $display("LT with N!=V PCS=1: PCSrc=%b", PCSrc);
    Cond     = 4'b1100;
    FlagW    = 2'b11;
    ALUFlags = 4'b0101;
    #1;
    sb_q.push_back(4'b0000);
    exp_v = sb_q.pop_front();
    total++;
    if (PCSrc !== exp_v[0]) begin
      bad++;
      $display("FAIL gt_pcsrc: got=%b want=%b", PCSrc, exp_v[0]);
    end
    $display("GT with N!=V PCS=1: PCSrc=%b", PCSrc);
    sb_q.push_back(4'b1000);
    step();
    FlagW = 2'b00;
    exp_v = sb_q.pop_front();
    total++;
    if (Flags !== exp_v) begin
      bad++;
      $display("FAIL gt_no_flagwrite: got=%b want=%b", Flags, exp_v);
    end
    $display("failed GT with FlagW=11: Flags=%b", Flags);
    // X strobes behind a failed condition must still gate to 0.
    PCS  = 1'bx;
    RegW = 1'bx;
    MemW = 1'bx;
    #1;
    sb_q.push_back(4'b0000);
    exp_v = sb_q.pop_front();
    total++;
    if ({1'b0, PCSrc, RegWrite, MemWrite} !== exp_v) begin
      bad++;
      $display("FAIL x_strobes: got=%b%b%b want=%b", PCSrc, RegWrite, MemWrite, exp_v[2:0]);
    end
    $display("X strobes with failed GT: PCSrc=%b RegWrite=%b MemWrite=%b", PCSrc, RegWrite, MemWrite);
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    set_flags(4'b0000);
    // The compare is itself conditional (NE); it must be judged on Z=0.
    Cond     = 4'b0001;
    FlagW    = 2'b11;
    ALUFlags = 4'b0100;
    RegW     = 1'b1;
    #1;
    sb_q.push_back(4'b0001);
    exp_v = sb_q.pop_front();
    total++;
    if (RegWrite !== exp_v[0]) begin
      bad++;
      $display("FAIL pre_update_condex: got=%b want=%b", RegWrite, exp_v[0]);
    end
    $display("cycle n NE on pre-update flags: RegWrite=%b", RegWrite);
    step();
    FlagW = 2'b00;
    Cond  = 4'b0000;
    #1;
    sb_q.push_back(4'b0001);
    exp_v = sb_q.pop_front();
    total++;
    if (RegWrite !== exp_v[0]) begin
      bad++;
      $display("FAIL next_cycle_eq: got=%b want=%b", RegWrite, exp_v[0]);
    end
    $display("cycle n+1 EQ sees Z=1: RegWrite=%b Flags=%b", RegWrite, Flags);
    idle_inputs();
  endtask

  task automatic test_sweep();
    int row_bad;
    for (int f = 0; f < 16; f++) begin
      row_bad = 0;
      set_flags(4'(f));
      sb_q.push_back(4'(f));
      exp_v = sb_q.pop_front();
      total++;
      if (Flags !== exp_v) begin
        bad++;
        row_bad++;
        $display("FAIL sweep_load: got=%b want=%b", Flags, exp_v);
      end
      RegW = 1'b1;
      for (int c = 0; c < 16; c++) begin
        Cond = 4'(c);
        #1;
        sb_q.push_back({3'b000, model_cond(4'(c), 4'(f))});
        exp_v = sb_q.pop_front();
        total++;
        if (RegWrite !== exp_v[0]) begin
          bad++;
          row_bad++;
          $display("FAIL sweep cond=%b flags=%b: got=%b want=%b", Cond, Flags, RegWrite, exp_v[0]);
        end
      end
      $display("sweep flags=%b: 16 conditions checked, %0d wrong", 4'(f), row_bad);
      idle_inputs();
    end
  endtask
`else
  task automatic test_multicycle();
    set_flags(4'b0100);
    Cond = 4'b0000;
    step();
    Cond = 4'b0001;
    RegW = 1'b1;
    #1;
    sb_q.push_back(4'b0001);
    exp_v = sb_q.pop_front();
    total++;
    if (RegWrite !== exp_v[0]) begin
      bad++;
      $display("FAIL mc_regwrite: got=%b want=%b", RegWrite, exp_v[0]);
    end
    $display("multicycle EQ then NE RegW=1: RegWrite=%b", RegWrite);
    RegW   = 1'b0;
    NextPC = 1'b1;
    PCS    = 1'b0;
    #1;
    sb_q.push_back(4'b0001);
    exp_v = sb_q.pop_front();
    total++;
    if (PCWrite !== exp_v[0]) begin
      bad++;
      $display("FAIL mc_nextpc: got=%b want=%b", PCWrite, exp_v[0]);
    end
    $display("NextPC=1 PCS=0: PCWrite=%b", PCWrite);
    NextPC = 1'b0;
    Cond   = 4'b1110;
    step();
    reset = 1'b1;
    RegW  = 1'b1;
    step();
    sb_q.push_back(4'b0000);
    exp_v = sb_q.pop_front();
    total++;
    if (RegWrite !== exp_v[0]) begin
      bad++;
      $display("FAIL mc_reset_clear: got=%b want=%b", RegWrite, exp_v[0]);
    end
    $display("reset mid-instruction: RegWrite=%b", RegWrite);
    reset = 1'b0;
    idle_inputs();
  endtask
`endif

  initial begin
    reset    = 1'b1;
    Cond     = 4'b0000;
    ALUFlags = 4'b0000;
    idle_inputs();
    test_reset();
    test_flag_update();
    test_split_halves();
`ifndef COND_MULTICYCLE_EN
    test_cond_fail();
    test_back_to_back();
    test_sweep();
`else
    test_multicycle();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
